// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-writer counters gating uop issue.
// Tracks in-flight destination writes so sources and destinations stall on hazards.
//
// Ports:
//   clk, reset              clock; asynchronous active-low reset
//   iss_valid               uop presented for issue
//   iss_src_en/iss_src0..2  up to three source register indices
//   iss_dst_en/iss_dst0..1  up to two destination register indices
//   iss_stall               combinational: uop must not issue this cycle
//   wb0_*/wb1_*             write-back ports, each retiring one pending write
//   flush                   redirect: enter DRAIN until all writes retire
//   busy                    per-register pending flag
//   drained                 all counters zero and FSM in RUN
//   err                     sticky counter-underflow flag
module reg_scoreboard #(
    parameter int NREG = 32,
    parameter int CNTW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            iss_valid,
    input  logic [2:0]      iss_src_en,
    input  logic [4:0]      iss_src0,
    input  logic [4:0]      iss_src1,
    input  logic [4:0]      iss_src2,
    input  logic [1:0]      iss_dst_en,
    input  logic [4:0]      iss_dst0,
    input  logic [4:0]      iss_dst1,
    output logic            iss_stall,
    input  logic            wb0_valid,
    input  logic [4:0]      wb0_reg,
    input  logic            wb1_valid,
    input  logic [4:0]      wb1_reg,
    input  logic            flush,
    output logic [NREG-1:0] busy,
    output logic            drained,
    output logic            err
);

    // Extra headroom bits so add/subtract never wrap before the range check.
    localparam int CW = CNTW + 2;
    localparam logic [CW-1:0] MAXC = CW'((1 << CNTW) - 1);

    typedef enum logic {
        S_RUN,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CNTW-1:0] r_cnt [NREG];
    logic            r_err;

    logic [1:0]      w_dec  [NREG];
    logic [CW-1:0]   w_ext  [NREG];
    logic [CW-1:0]   w_post [NREG];
    logic [CNTW-1:0] w_nxt  [NREG];
    logic [NREG-1:0] w_uflow;

    // 32-entry views indexed directly by the 5-bit register fields;
    // entries at or above NREG stay zero so those indices never stall.
    logic [31:0] w_busy32;
    logic [31:0] w_post_busy32;
    logic [31:0] w_post_max32;
    logic        w_post_zero;

    logic w_src_hit;
    logic w_dst_hit;
    logic w_issue;

    always_comb begin
        w_busy32      = '0;
        w_post_busy32 = '0;
        w_post_max32  = '0;
        w_post_zero   = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            w_dec[i] = {1'b0, (wb0_valid && (wb0_reg == 5'(i)))}
                     + {1'b0, (wb1_valid && (wb1_reg == 5'(i)))};
            w_ext[i] = CW'(r_cnt[i]);
            // Saturating post-write-back count for destination checks.
            w_post[i] = (w_ext[i] >= CW'(w_dec[i]))
                      ? (w_ext[i] - CW'(w_dec[i])) : '0;
            w_busy32[i]      = |r_cnt[i];
            w_post_busy32[i] = |w_post[i];
            w_post_max32[i]  = (w_post[i] == MAXC);
            if (|w_post[i]) begin
                w_post_zero = 1'b0;
            end
        end
    end

    // Sources see the pre-write-back busy state: no same-cycle bypass.
    always_comb begin
        w_src_hit = (iss_src_en[0] && w_busy32[iss_src0])
                 || (iss_src_en[1] && w_busy32[iss_src1])
                 || (iss_src_en[2] && w_busy32[iss_src2]);
        w_dst_hit = (iss_dst_en[0] && (w_post_busy32[iss_dst0]
                                    || w_post_max32[iss_dst0]))
                 || (iss_dst_en[1] && (w_post_busy32[iss_dst1]
                                    || w_post_max32[iss_dst1]));
        iss_stall = w_src_hit || w_dst_hit || flush
                 || (r_state == S_DRAIN);
        w_issue   = iss_valid && !iss_stall;
    end

    // Issue increments and write-back decrements merge into one update.
    always_comb begin
        logic          v_inc;
        logic [CW-1:0] v_sum;
        v_inc   = 1'b0;
        v_sum   = '0;
        w_uflow = '0;
        for (int i = 0; i < NREG; i++) begin
            v_inc = w_issue
                 && ((iss_dst_en[0] && (iss_dst0 == 5'(i)))
                  || (iss_dst_en[1] && (iss_dst1 == 5'(i))));
            v_sum = w_ext[i] + CW'(v_inc);
            if (v_sum < CW'(w_dec[i])) begin
                w_nxt[i]   = '0;
                w_uflow[i] = 1'b1;
            end else begin
                w_nxt[i] = CNTW'(v_sum - CW'(w_dec[i]));
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_RUN: begin
                if (flush) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!flush && w_post_zero) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_RUN;
            r_err   <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_err   <= r_err || (|w_uflow);
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= w_nxt[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            busy[i] = |r_cnt[i];
        end
    end

    assign drained = (r_state == S_RUN) && !(|busy);
    assign err     = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard.
// Directed hazard scenarios plus randomized traffic against a counter model.
module tb_reg_scoreboard;

    localparam int NREG = 16;
    localparam int MAXC = 3;

    logic            clk;
    logic            reset;
    logic            iss_valid;
    logic [2:0]      iss_src_en;
    logic [4:0]      s0, s1, s2;
    logic [1:0]      iss_dst_en;
    logic [4:0]      d0, d1;
    logic            iss_stall;
    logic            wb0_valid, wb1_valid;
    logic [4:0]      wb0_reg, wb1_reg;
    logic            flush;
    logic [NREG-1:0] busy;
    logic            drained;
    logic            err;

    int checks = 0;
    int failures = 0;

    int m_cnt [NREG];
    bit m_drain;
    bit m_err;

    reg_scoreboard #(.NREG(NREG), .CNTW(2)) dut (
        .clk(clk), .reset(reset),
        .iss_valid(iss_valid), .iss_src_en(iss_src_en),
        .iss_src0(s0), .iss_src1(s1), .iss_src2(s2),
        .iss_dst_en(iss_dst_en), .iss_dst0(d0), .iss_dst1(d1),
        .iss_stall(iss_stall),
        .wb0_valid(wb0_valid), .wb0_reg(wb0_reg),
        .wb1_valid(wb1_valid), .wb1_reg(wb1_reg),
        .flush(flush), .busy(busy), .drained(drained), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_dec(int r);
        int d = 0;
        if (wb0_valid && int'(wb0_reg) == r) d++;
        if (wb1_valid && int'(wb1_reg) == r) d++;
        return d;
    endfunction

    function automatic int m_post(int r);
        int p = m_cnt[r] - m_dec(r);
        return (p < 0) ? 0 : p;
    endfunction

    function automatic bit m_stall();
        bit s;
        int src [3];
        int dst [2];
        src[0] = int'(s0); src[1] = int'(s1); src[2] = int'(s2);
        dst[0] = int'(d0); dst[1] = int'(d1);
        s = m_drain || flush;
        for (int k = 0; k < 3; k++)
            if (iss_src_en[k] && src[k] < NREG && m_cnt[src[k]] != 0)
                s = 1;
        for (int k = 0; k < 2; k++)
            if (iss_dst_en[k] && dst[k] < NREG)
                if (m_post(dst[k]) != 0 || m_post(dst[k]) == MAXC)
                    s = 1;
        return s;
    endfunction

    function automatic void m_update(bit issue);
        int nc [NREG];
        bit allz = 1;
        for (int r = 0; r < NREG; r++) begin
            int inc;
            int v;
            inc = (issue && ((iss_dst_en[0] && int'(d0) == r)
                          || (iss_dst_en[1] && int'(d1) == r))) ? 1 : 0;
            v = m_cnt[r] + inc - m_dec(r);
            if (v < 0) begin
                v = 0;
                m_err = 1;
            end
            nc[r] = v;
            if (m_post(r) != 0) allz = 0;
        end
        if (!m_drain && flush) m_drain = 1;
        else if (m_drain && !flush && allz) m_drain = 0;
        for (int r = 0; r < NREG; r++) m_cnt[r] = nc[r];
    endfunction

    function automatic void m_reset();
        for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
        m_drain = 0;
        m_err = 0;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        for (int r = 0; r < NREG; r++) b[r] = (m_cnt[r] != 0);
        return b;
    endfunction

    function automatic bit m_drained();
        return !m_drain && (m_busy() == 0);
    endfunction

    task automatic idle();
        iss_valid = 0; iss_src_en = 0; iss_dst_en = 0;
        s0 = 0; s1 = 0; s2 = 0; d0 = 0; d1 = 0;
        wb0_valid = 0; wb1_valid = 0; wb0_reg = 0; wb1_reg = 0;
        flush = 0;
    endtask

    // Called at posedge+1 with inputs already set; ends at posedge+1.
    task automatic step();
        bit es;
        #2;
        es = m_stall();
        chk("stall", {31'b0, iss_stall}, {31'b0, es});
        @(posedge clk);
        m_update(iss_valid && !es);
        #1;
        chk("busy", {{(32-NREG){1'b0}}, busy}, m_busy());
        chk("drained", {31'b0, drained}, {31'b0, m_drained()});
        chk("err", {31'b0, err}, {31'b0, m_err});
    endtask

    task automatic do_reset();
        idle();
        #3;
        reset = 0;
        #1;
        m_reset();
        chk("rst_busy", {{(32-NREG){1'b0}}, busy}, 32'h0);
        chk("rst_drained", {31'b0, drained}, 32'h1);
        chk("rst_err", {31'b0, err}, 32'h0);
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic iss_dst(input logic [4:0] a);
        iss_valid = 1; iss_dst_en = 2'b01; d0 = a;
    endtask

    initial begin
        reset = 1;
        idle();
        m_reset();
        @(posedge clk);
        #1;
        do_reset();
        #2;
        chk("idle_stall", {31'b0, iss_stall}, 32'h0);
        #2;
        step();

        // RAW: producer to reg 3, consumer stalls until write-back.
        iss_dst(5'd3);
        step();
        chk("r035_busy3", {31'b0, busy[3]}, 32'h1);
        idle();
        iss_valid = 1; iss_src_en = 3'b001; s0 = 5'd3;
        #2;
        chk("r035_stall", {31'b0, iss_stall}, 32'h1);
        #2;
        step();
        wb0_valid = 1; wb0_reg = 5'd3;
        step();
        chk("r035_clr", {31'b0, busy[3]}, 32'h0);
        wb0_valid = 0;
        #2;
        chk("r035_go", {31'b0, iss_stall}, 32'h0);
        #2;
        step();

        // Double destination retired on both ports at once.
        idle();
        iss_valid = 1; iss_dst_en = 2'b11; d0 = 5'd0; d1 = 5'd2;
        step();
        chk("r036_busy", {30'b0, busy[2], busy[0]}, 32'h3);
        idle();
        wb0_valid = 1; wb0_reg = 5'd0; wb1_valid = 1; wb1_reg = 5'd2;
        step();
        chk("r036_clr", {30'b0, busy[2], busy[0]}, 32'h0);
        chk("r036_drn", {31'b0, drained}, 32'h1);

        // Same-cycle reissue to a retiring register keeps count at 1.
        idle();
        iss_dst(5'd7);
        step();
        iss_dst(5'd7);
        wb0_valid = 1; wb0_reg = 5'd7;
        #2;
        chk("r037_nostall", {31'b0, iss_stall}, 32'h0);
        #2;
        step();
        chk("r037_busy7", {31'b0, busy[7]}, 32'h1);
        idle();
        wb1_valid = 1; wb1_reg = 5'd7;
        step();
        chk("r037_clr", {31'b0, busy[7]}, 32'h0);

        // Flush with two pending writes: drain, then resume.
        idle();
        iss_dst(5'd5);
        step();
        iss_dst(5'd6);
        step();
        iss_dst(5'd8);
        flush = 1;
        step();
        flush = 0;
        step();
        chk("r038_drn0", {31'b0, drained}, 32'h0);
        wb0_valid = 1; wb0_reg = 5'd5;
        step();
        wb0_reg = 5'd6;
        step();
        chk("r038_drn1", {31'b0, drained}, 32'h1);
        wb0_valid = 0;
        step();
        chk("r038_busy8", {31'b0, busy[8]}, 32'h1);
        idle();
        wb0_valid = 1; wb0_reg = 5'd8;
        step();

        // Flush together with issue: no increment.
        idle();
        iss_dst(5'd4);
        flush = 1;
        step();
        chk("r040_busy4", {31'b0, busy[4]}, 32'h0);
        idle();
        step();

        // Underflow is sticky; reset mid-drain clears everything.
        wb0_valid = 1; wb0_reg = 5'd9;
        step();
        chk("r039_err", {31'b0, err}, 32'h1);
        idle();
        step();
        step();
        chk("r039_sticky", {31'b0, err}, 32'h1);
        iss_dst(5'd1);
        step();
        idle();
        flush = 1;
        step();
        do_reset();

        // Randomized traffic, including out-of-range indices.
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 149) begin
                do_reset();
            end else begin
                iss_valid  = ($urandom_range(0, 3) != 0);
                iss_src_en = 3'($urandom);
                iss_dst_en = 2'($urandom);
                s0 = 5'($urandom_range(0, 19));
                s1 = 5'($urandom_range(0, 19));
                s2 = 5'($urandom_range(0, 19));
                d0 = 5'($urandom_range(0, 19));
                d1 = ($urandom_range(0, 3) == 0) ? d0
                                                 : 5'($urandom_range(0, 19));
                wb0_valid = $urandom_range(0, 1);
                wb1_valid = $urandom_range(0, 1);
                wb0_reg = 5'($urandom_range(0, 19));
                wb1_reg = ($urandom_range(0, 3) == 0) ? wb0_reg
                                                      : 5'($urandom_range(0, 19));
                flush = ($urandom_range(0, 15) == 0);
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
